// File: rtl/cg_sweep_bist_ctrl.sv
// Exhaustive-sweep BIST controller: walks every input vector into a combinational netlist and MISR-compacts its responses.
// Optional raw capture outputs (cap_valid/cap_data/cap_idx) are enabled by defining CG_SWEEP_RAW_OUT_EN.
module cg_sweep_bist_ctrl #(
  parameter int unsigned      IN_W   = 3,
  parameter int unsigned      OUT_W  = 12,
  parameter int unsigned      SETTLE = 2,
  parameter logic [OUT_W-1:0] POLY   = 12'h829
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] golden_sig,
  input  logic [OUT_W-1:0] dut_f,
  output logic [IN_W-1:0]  dut_x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
`ifdef CG_SWEEP_RAW_OUT_EN
  ,
  output logic             cap_valid,
  output logic [OUT_W-1:0] cap_data,
  output logic [IN_W-1:0]  cap_idx
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IN_W-1:0]  X_LAST   = '1;
  localparam logic [IN_W-1:0]  X_ONE    = IN_W'(1);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic [OUT_W-1:0] misr_next;

`ifdef CG_SWEEP_RAW_OUT_EN
  logic             cap_valid_q, cap_valid_d;
  logic [OUT_W-1:0] cap_data_q, cap_data_d;
  logic [IN_W-1:0]  cap_idx_q, cap_idx_d;
`endif

  // With SETTLE==0 the controller skips the settle state and captures back to back.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    misr_next = {sig_q[OUT_W-2:0], ^(sig_q & POLY)} ^ dut_f;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_d     = '0;
          sig_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_CAPTURE: begin
        sig_d = misr_next;
        if (x_q == X_LAST) begin
          pass_d  = (misr_next == golden_sig);
          state_d = ST_DONE;
        end else begin
          x_d     = x_q + X_ONE;
          state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_x     = x_q;
  assign signature = sig_q;
  assign pass      = pass_q;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done      = (state_q == ST_DONE);

`ifdef CG_SWEEP_RAW_OUT_EN
  // Raw tap mirrors exactly what the MISR absorbed on each capture edge.
  always_comb begin
    cap_valid_d = (state_q == ST_CAPTURE);
    cap_data_d  = cap_data_q;
    cap_idx_d   = cap_idx_q;
    if (state_q == ST_CAPTURE) begin
      cap_data_d = dut_f;
      cap_idx_d  = x_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_idx_q   <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_idx_q   <= cap_idx_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign cap_idx   = cap_idx_q;
`endif

endmodule

// File: tb/tb_cg_sweep_bist_ctrl.sv
// Scoreboard bench for cg_sweep_bist_ctrl: one instance with default SETTLE, one with SETTLE=0.
// Raw capture port checks are compiled in when CG_SWEEP_RAW_OUT_EN is defined.
module tb_cg_sweep_bist_ctrl;

  typedef struct {
    logic [11:0] sig;
    logic        pass;
  } expRes_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start0;
  logic [11:0] golden;
  int          fMode;

  logic [2:0]  dutX, dutX0;
  logic [11:0] dutF, dutF0;
  logic [11:0] sig, sig0;
  logic        busy, done, pass;
  logic        busy0, done0, pass0;

`ifdef CG_SWEEP_RAW_OUT_EN
  logic        capValid, capValid0;
  logic [11:0] capData, capData0;
  logic [2:0]  capIdx, capIdx0;
`endif

  expRes_t     sbQ[$];
  logic [2:0]  xQ[$];
  int          checkCount = 0;
  int          failCount  = 0;

  always #5 clk = ~clk;

  // Netlist stand-in: a few response patterns selected by fMode.
  function automatic logic [11:0] netModel(input int mode, input logic [2:0] x);
    logic [2:0] t;
    t = x + 3'd3;
    case (mode)
      0:       netModel = 12'h000;
      1:       netModel = 12'h001;
      default: netModel = {x, ~x, x ^ 3'b101, t};
    endcase
  endfunction

  function automatic logic [11:0] misrModel(input int mode);
    logic [11:0] s;
    logic        fb;
    s = 12'h000;
    for (int v = 0; v < 8; v++) begin
      fb = ^(s & 12'h829);
      s  = {s[10:0], fb} ^ netModel(mode, v[2:0]);
    end
    misrModel = s;
  endfunction

  assign dutF  = netModel(fMode, dutX);
  assign dutF0 = netModel(fMode, dutX0);

  cg_sweep_bist_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .golden_sig (golden),
    .dut_f      (dutF),
    .dut_x      (dutX),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (sig)
`ifdef CG_SWEEP_RAW_OUT_EN
    ,
    .cap_valid  (capValid),
    .cap_data   (capData),
    .cap_idx    (capIdx)
`endif
  );

  cg_sweep_bist_ctrl #(.SETTLE(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .golden_sig (golden),
    .dut_f      (dutF0),
    .dut_x      (dutX0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .signature  (sig0)
`ifdef CG_SWEEP_RAW_OUT_EN
    ,
    .cap_valid  (capValid0),
    .cap_data   (capData0),
    .cap_idx    (capIdx0)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic pulseStart(input int sel);
    if (sel == 0) start = 1'b1;
    else          start0 = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  // Queue the expected outcome of a sweep, then launch it.
  task automatic applyStimulus(input int sel, input int mode, input logic [11:0] gold);
    expRes_t e;
    int      v;
    fMode  = mode;
    golden = gold;
    e.sig  = misrModel(mode);
    e.pass = (e.sig == gold);
    sbQ.push_back(e);
    xQ.delete();
    if (sel == 0) begin
      for (int n = 1; n <= 24; n++) begin
        v = (n / 3 > 7) ? 7 : n / 3;
        xQ.push_back(v[2:0]);
      end
    end
    pulseStart(sel);
    checkOutput("busy_after_start", (sel == 0) ? busy : busy0, 1);
  endtask

  // Run until done (bounded), checking vector order, raw taps and the final scoreboard entry.
  task automatic waitDone(input int sel, input int expEdges, input bit poke);
    expRes_t e;
    int      edges = 0;
    int      caps  = 0;
    for (int i = 0; i < 100; i++) begin
      if (poke && (i == 4 || i == 11 || i == 20)) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
      if (sel == 0 && xQ.size() > 0) checkOutput("dut_x_seq", dutX, xQ.pop_front());
`ifdef CG_SWEEP_RAW_OUT_EN
      if ((sel == 0) ? capValid : capValid0) begin
        checkOutput("cap_idx", (sel == 0) ? capIdx : capIdx0, caps);
        checkOutput("cap_data", (sel == 0) ? capData : capData0, netModel(fMode, caps[2:0]));
        caps++;
      end
`endif
      if ((sel == 0) ? done : done0) break;
    end
    checkOutput("done_latency", edges, expEdges);
    checkOutput("busy_at_done", (sel == 0) ? busy : busy0, 0);
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_nonempty", 0, 1);
    end else begin
      e = sbQ.pop_front();
      checkOutput("signature", (sel == 0) ? sig : sig0, e.sig);
      checkOutput("pass", (sel == 0) ? pass : pass0, e.pass);
    end
`ifdef CG_SWEEP_RAW_OUT_EN
    checkOutput("cap_count", caps, 8);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    fMode  = 0;
    golden = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dut_x", dutX, 0);
    checkOutput("rst_sig", sig, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_done0", done0, 0);
`ifdef CG_SWEEP_RAW_OUT_EN
    checkOutput("rst_cap_valid", capValid, 0);
    checkOutput("rst_cap_data", capData, 0);
    checkOutput("rst_cap_idx", capIdx, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] zero response, golden 0");
    applyStimulus(0, 0, 12'h000);
    waitDone(0, 24, 0);
    checkOutput("zero_sig_const", sig, 12'h000);

    $display("[TB] constant 1 response, matching and off-by-one golden");
    applyStimulus(0, 1, 12'h0A5);
    waitDone(0, 24, 0);
    checkOutput("one_sig_const", sig, 12'h0A5);
    checkOutput("one_pass_const", pass, 1);
    applyStimulus(0, 1, 12'h0A4);
    waitDone(0, 24, 0);
    checkOutput("one_fail_const", pass, 0);

    $display("[TB] netlist model with start pokes while busy");
    applyStimulus(0, 2, misrModel(2));
    waitDone(0, 24, 1);
    checkOutput("done_holds_x", dutX, 7);

    $display("[TB] reset mid-sweep");
    fMode = 2;
    pulseStart(0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_dut_x", dutX, 0);
    checkOutput("midrst_sig", sig, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    applyStimulus(0, 2, misrModel(2));
    waitDone(0, 24, 0);

    $display("[TB] SETTLE=0 instance, two back-to-back sweeps");
    applyStimulus(1, 1, 12'h0A5);
    waitDone(1, 8, 0);
    checkOutput("s0_sig_const", sig0, 12'h0A5);
    applyStimulus(1, 1, 12'h0A5);
    waitDone(1, 8, 0);
    checkOutput("s0_rerun_sig_const", sig0, 12'h0A5);
    checkOutput("s0_rerun_pass", pass0, 1);

    $display("[TB] reset and start on the same edge");
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_wins_busy", busy, 0);
    checkOutput("rst_wins_done", done, 0);
    checkOutput("rst_wins_sig", sig, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_wins_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/cg_sweep_bist_ctrl.md
# cg_sweep_bist_ctrl

Exhaustive-sweep self-test controller for the small generated combinational benchmark netlists (3-input / 12-output class). It drives every input vector into the netlist in ascending order and waits a programmable settle time per vector. It compacts each 12-bit response into a MISR signature and compares the final signature against a golden value. It sits between the test harness and one combinational netlist instance; the netlist itself is untouched.

## Interface

- IN_W, 3, netlist input width; sweep covers 2^IN_W vectors
- OUT_W, 12, netlist output width and MISR width
- SETTLE, 2, idle cycles between applying a vector and capturing it (0 legal)
- POLY, 12'h829, MISR feedback tap mask (width OUT_W)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin sweep; sampled in IDLE or DONE only
- golden_sig  in  OUT_W  expected signature; sampled on entry to DONE
- dut_f  in  OUT_W  netlist outputs
- dut_x  out  IN_W  netlist inputs (registered)
- busy  out  1  high in SETTLE/CAPTURE
- done  out  1  high in DONE
- pass  out  1  signature == golden_sig; valid while done
- signature  out  OUT_W  current MISR value

## Operation

- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE/DONE + start: dut_x<=0, signature<=0, cnt<=0, pass<=0; go to SETTLE, or go directly to CAPTURE if SETTLE==0.
- SETTLE: cnt increments each cycle; at cnt==SETTLE-1, cnt<=0 and go to CAPTURE.
- CAPTURE: signature <= {signature[OUT_W-2:0], fb} ^ dut_f, where fb = ^(signature & POLY).
  - If dut_x == 2^IN_W-1: pass <= (next signature == golden_sig); go to DONE.
  - Otherwise: dut_x <= dut_x+1; go to SETTLE (or stay in CAPTURE if SETTLE==0).
- DONE: hold signature, pass and dut_x (the all-ones vector). start re-arms from DONE exactly as from IDLE.
- start while busy: ignored, no effect.
- dut_x increments without wrap; the last vector ends the sweep.

## Timing

- Reset values: state IDLE, dut_x=0, signature=0, busy=0, done=0, pass=0, cnt=0.
- rst mid-sweep: all of the above restored on that edge; the partial signature is discarded.
- Edge E0 samples start; busy is high after E0.
- Each vector occupies SETTLE+1 edges.
- done and pass are valid after edge E0 + 2^IN_W*(SETTLE+1). With defaults this is E24.
- dut_f is sampled at the CAPTURE edge, so a vector is stable for SETTLE+1 cycles before sampling.
- rst and start on the same edge: rst wins.

## Configuration

- CG_SWEEP_RAW_OUT_EN defined: adds three output ports:
  - cap_valid (1): a registered one-cycle pulse on the cycle after each CAPTURE edge.
  - cap_data (OUT_W): the dut_f value sampled at that edge.
  - cap_idx (IN_W): the vector that was captured.
  - Reset values: cap_valid=0, cap_data=0, cap_idx=0.
- Not defined: these ports are absent and the behaviour is otherwise identical.

## Test plan

- dut_f tied to 12'h000, golden_sig=0, start pulse → done after 24 edges, signature=12'h000, pass=1.
- dut_f tied to 12'h001, golden_sig=12'h0A5 → signature=12'h0A5, pass=1. Repeat with golden_sig=12'h0A4 → pass=0.
- Netlist model in loop, check dut_x sequence 0..7, each held 3 cycles, monotonic; start pulses during busy → no restart, done still at E24.
- rst asserted at E10 mid-sweep → next cycle IDLE, dut_x=0, signature=0, busy=0. A new start then completes normally at E24 relative to the new start.
- SETTLE=0, dut_f=12'h001 → done after 8 edges, signature=12'h0A5. A second start from DONE repeats with an identical result.
- CG_SWEEP_RAW_OUT_EN with dut_f=netlist model → 8 cap_valid pulses, cap_idx 0..7, cap_data matching the model outputs per vector.
